ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/mips_pkg.sv | 34 +++
 rtl/seq_mult16.sv | 81 ++++++++
 rtl/ex_mem_stage.sv | 147 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared widths, ALU decode constants, ctrl bit positions and multiply FSM
// state for the MIPS-style EX/MEM stage.
package mips_pkg;
  localparam int WIDTH = 16;
  localparam int RBITS = 3;
  localparam int CTRL_W = 5;
  localparam int MUL_ITERS = 16;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_RSVD = 2'b11;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_NOR = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  // ctrl = {memtoReg, regWrite, memRead, memWrite, branch}
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 1;
  localparam int CTRL_BRANCH   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } mulState_t;
endpackage

// File: rtl/seq_mult16.sv
// Sixteen-iteration shift-add multiplier; product is the low WIDTH bits.
// done/product are combinational and describe the edge doing the last iteration.
module seq_mult16
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  mulState_t stateReg, stateNext;
  logic [3:0] countReg, countNext;
  logic [WIDTH-1:0] accReg, accNext, mcandReg, mcandNext, mplierReg, mplierNext;
  logic [WIDTH-1:0] accStep;

  assign accStep = mplierReg[0] ? accReg + mcandReg : accReg;
  assign busy    = (stateReg == MUL);
  assign done    = busy && !hold && !abort && (countReg == 4'(MUL_ITERS - 1));
  assign product = accStep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      countReg  <= '0;
      accReg    <= '0;
      mcandReg  <= '0;
      mplierReg <= '0;
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      accReg    <= accNext;
      mcandReg  <= mcandNext;
      mplierReg <= mplierNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    accNext    = accReg;
    mcandNext  = mcandReg;
    mplierNext = mplierReg;
    if (!hold) begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            stateNext  = MUL;
            countNext  = '0;
            accNext    = '0;
            mcandNext  = a;
            mplierNext = b;
          end
        end
        MUL: begin
          if (abort) begin
            stateNext = IDLE;
            countNext = '0;
          end else begin
            accNext    = accStep;
            mcandNext  = mcandReg << 1;
            mplierNext = mplierReg >> 1;
            countNext  = countReg + 4'd1;
            if (done) begin
              stateNext = IDLE;
              countNext = '0;
            end
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_mem_stage.sv
// EX stage ALU plus EX/MEM pipeline register; multiplies run on seq_mult16
// and emit bubbles until the product is ready.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH,
  parameter int RBITS = mips_pkg::RBITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              flush,
  input  logic [WIDTH-1:0]  nextinst,
  input  logic              regDst,
  input  logic              ALUSrc,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        opCode,
  input  logic [WIDTH-1:0]  readData1,
  input  logic [WIDTH-1:0]  readData2,
  input  logic [WIDTH-1:0]  signExtend,
  input  logic [RBITS-1:0]  rt,
  input  logic [RBITS-1:0]  rd,
  output logic              busy,
  output logic [WIDTH-1:0]  aluResultOut,
  output logic [WIDTH-1:0]  writeDataOut,
  output logic [RBITS-1:0]  writeRegOut,
  output logic [WIDTH-1:0]  branchTargetOut,
  output logic              zeroOut,
  output logic              pcSrcOut,
  output logic [CTRL_W-1:0] ctrlOut
);
  logic [WIDTH-1:0]  opB, aluResult, branchTarget, mulProduct;
  logic [RBITS-1:0]  writeDest;
  logic [CTRL_W-1:0] ctrlEff;
  logic              isMul, isNop, mulStart, mulDone;

  logic [WIDTH-1:0]  aluResultReg, writeDataReg, branchTargetReg;
  logic [RBITS-1:0]  writeRegReg;
  logic              zeroReg, pcSrcReg;
  logic [CTRL_W-1:0] ctrlReg;
  logic [WIDTH-1:0]  capWriteDataReg, capBranchTargetReg;
  logic [RBITS-1:0]  capWriteRegReg;
  logic [CTRL_W-1:0] capCtrlReg;

  assign branchTarget = nextinst + signExtend;
  assign writeDest    = regDst ? rd : rt;

  always_comb begin
    opB       = ALUSrc ? signExtend : readData2;
    aluResult = '0;
    isMul     = 1'b0;
    isNop     = 1'b0;
    case (ALUOp)
      ALUOP_SUB: aluResult = readData1 - opB;
      ALUOP_FUNC: begin
        case (opCode)
          OP_ADD: aluResult = readData1 + opB;
          OP_SUB: aluResult = readData1 - opB;
          OP_AND: aluResult = readData1 & opB;
          OP_OR:  aluResult = readData1 | opB;
          OP_SLT: aluResult = {{(WIDTH-1){1'b0}}, ($signed(readData1) < $signed(opB))};
          OP_MUL: isMul = 1'b1;
          OP_NOR: aluResult = ~(readData1 | opB);
          OP_NOP: isNop = 1'b1;
          default: aluResult = '0;
        endcase
      end
      default: aluResult = readData1 + opB;  // 00 and reserved 11
    endcase
  end

  // A nop must never write the register file.
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrlMask
      assign ctrlEff[gi] = ctrl[gi] & ~(isNop && (gi == CTRL_REGWRITE));
    end
  endgenerate

  assign mulStart = hit && !flush && !busy && isMul;

  seq_mult16 #(.WIDTH(WIDTH)) uMult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mulStart),
    .abort   (flush),
    .hold    (!hit),
    .a       (readData1),
    .b       (opB),
    .busy    (busy),
    .done    (mulDone),
    .product (mulProduct)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluResultReg       <= '0;
      writeDataReg       <= '0;
      writeRegReg        <= '0;
      branchTargetReg    <= '0;
      zeroReg            <= 1'b0;
      pcSrcReg           <= 1'b0;
      ctrlReg            <= '0;
      capWriteDataReg    <= '0;
      capBranchTargetReg <= '0;
      capWriteRegReg     <= '0;
      capCtrlReg         <= '0;
    end else if (hit) begin
      if (flush || (busy && !mulDone) || mulStart) begin
        aluResultReg <= '0;
        ctrlReg      <= '0;
        pcSrcReg     <= 1'b0;
        if (mulStart) begin
          capWriteDataReg    <= readData2;
          capBranchTargetReg <= branchTarget;
          capWriteRegReg     <= writeDest;
          capCtrlReg         <= ctrlEff;
        end
      end else if (busy) begin
        aluResultReg    <= mulProduct;
        zeroReg         <= (mulProduct == '0);
        pcSrcReg        <= capCtrlReg[CTRL_BRANCH] && (mulProduct == '0);
        ctrlReg         <= capCtrlReg;
        writeDataReg    <= capWriteDataReg;
        writeRegReg     <= capWriteRegReg;
        branchTargetReg <= capBranchTargetReg;
      end else begin
        aluResultReg    <= aluResult;
        zeroReg         <= (aluResult == '0);
        pcSrcReg        <= ctrlEff[CTRL_BRANCH] && (aluResult == '0);
        ctrlReg         <= ctrlEff;
        writeDataReg    <= readData2;
        writeRegReg     <= writeDest;
        branchTargetReg <= branchTarget;
      end
    end
  end

  assign aluResultOut    = aluResultReg;
  assign writeDataOut    = writeDataReg;
  assign writeRegOut     = writeRegReg;
  assign branchTargetOut = branchTargetReg;
  assign zeroOut         = zeroReg;
  assign pcSrcOut        = pcSrcReg;
  assign ctrlOut         = ctrlReg;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: transaction-level reference model (remaining-iteration
// count, product via '*') checked every cycle, plus directed literal checks.
module tb_ex_mem_stage;
  import mips_pkg::*;
  localparam int W = 16;
  localparam int R = 3;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         hit, flush, regDst, ALUSrc;
  logic [W-1:0] nextinst, readData1, readData2, signExtend;
  logic [4:0]   ctrl;
  logic [1:0]   ALUOp;
  logic [2:0]   opCode;
  logic [R-1:0] rt, rd;
  logic         busy, zeroOut, pcSrcOut;
  logic [W-1:0] aluResultOut, writeDataOut, branchTargetOut;
  logic [R-1:0] writeRegOut;
  logic [4:0]   ctrlOut;

  ex_mem_stage #(.WIDTH(W), .RBITS(R)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .flush(flush), .nextinst(nextinst),
    .regDst(regDst), .ALUSrc(ALUSrc), .ctrl(ctrl), .ALUOp(ALUOp), .opCode(opCode),
    .readData1(readData1), .readData2(readData2), .signExtend(signExtend),
    .rt(rt), .rd(rd), .busy(busy), .aluResultOut(aluResultOut),
    .writeDataOut(writeDataOut), .writeRegOut(writeRegOut),
    .branchTargetOut(branchTargetOut), .zeroOut(zeroOut), .pcSrcOut(pcSrcOut),
    .ctrlOut(ctrlOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] alu, wd, bt;
    logic [R-1:0] wr;
    logic         zero, pc;
    logic [4:0]   c;
  } res_t;

  res_t expRes, mulCap;
  logic expValid;
  logic mPending;
  int   mRemain;
  int   tests = 0, failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t compute();
    res_t r;
    logic [W-1:0] b;
    logic [31:0] p;
    b = ALUSrc ? signExtend : readData2;
    r.c = ctrl;
    r.alu = '0;
    if (ALUOp == 2'b01) r.alu = readData1 - b;
    else if (ALUOp == 2'b10) begin
      case (opCode)
        3'd0: r.alu = readData1 + b;
        3'd1: r.alu = readData1 - b;
        3'd2: r.alu = readData1 & b;
        3'd3: r.alu = readData1 | b;
        3'd4: r.alu = ($signed(readData1) < $signed(b)) ? 16'd1 : 16'd0;
        3'd5: begin p = 32'(readData1) * 32'(b); r.alu = p[W-1:0]; end
        3'd6: r.alu = ~(readData1 | b);
        default: begin r.alu = '0; r.c[3] = 1'b0; end
      endcase
    end else r.alu = readData1 + b;
    r.zero = (r.alu == 0);
    r.pc   = r.c[0] & r.zero;
    r.wr   = regDst ? rd : rt;
    r.bt   = nextinst + signExtend;
    r.wd   = readData2;
    return r;
  endfunction

  task automatic resetModel();
    expRes = '0; expValid = 1'b1; mPending = 1'b0; mRemain = 0;
  endtask

  task automatic bubble();
    expRes.alu = '0; expRes.c = '0; expRes.pc = 1'b0; expValid = 1'b0;
  endtask

  task automatic modelEdge();
    if (!rst_n || !hit) return;
    if (flush) begin
      bubble(); mPending = 1'b0;
    end else if (mPending) begin
      mRemain--;
      if (mRemain == 0) begin expRes = mulCap; expValid = 1'b1; mPending = 1'b0; end
      else bubble();
    end else if (ALUOp == 2'b10 && opCode == 3'b101) begin
      mulCap = compute(); mPending = 1'b1; mRemain = 16; bubble();
    end else begin
      expRes = compute(); expValid = 1'b1;
    end
  endtask

  task automatic checkAll();
    chk("busy", busy, mPending);
    chk("aluResult", aluResultOut, expRes.alu);
    chk("ctrl", ctrlOut, expRes.c);
    chk("pcSrc", pcSrcOut, expRes.pc);
    if (expValid) begin
      chk("zero", zeroOut, expRes.zero);
      chk("writeReg", writeRegOut, expRes.wr);
      chk("writeData", writeDataOut, expRes.wd);
      chk("branchTarget", branchTargetOut, expRes.bt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic setIdle();
    hit = 1'b1; flush = 1'b0; regDst = 1'b0; ALUSrc = 1'b0; ctrl = '0;
    ALUOp = 2'b00; opCode = '0; readData1 = '0; readData2 = '0;
    signExtend = '0; nextinst = '0; rt = '0; rd = '0;
  endtask

  task automatic setMul(input logic [W-1:0] a, input logic [W-1:0] b);
    setIdle();
    ALUOp = 2'b10; opCode = 3'b101; readData1 = a; readData2 = b;
    ctrl = 5'b01000; regDst = 1'b1; rd = 3'd5;
  endtask

  task automatic scrambleIgnored();
    readData1 = 16'($urandom); readData2 = 16'($urandom);
    ALUOp = 2'($urandom_range(0, 3)); opCode = 3'($urandom_range(0, 7));
    ctrl = 5'($urandom); rd = 3'($urandom);
  endtask

  int n, edges;

  initial begin
    setIdle();
    resetModel();
    tick();
    chk("reset_alu", aluResultOut, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // R-type add 5+7 into rd=3
    setIdle(); ALUOp = 2'b10; opCode = 3'b000; readData1 = 16'd5; readData2 = 16'd7;
    regDst = 1'b1; rd = 3'd3; rt = 3'd6; ctrl = 5'b01000;
    tick();
    chk("add_result", aluResultOut, 16'd12);
    chk("add_writeReg", writeRegOut, 3'd3);
    chk("add_zero", zeroOut, 1'b0);

    // beq taken with negative offset
    setIdle(); ALUOp = 2'b01; readData1 = 16'd9; readData2 = 16'd9; ctrl = 5'b00001;
    nextinst = 16'd2; signExtend = 16'hFFFE;
    tick();
    chk("beq_zero", zeroOut, 1'b1);
    chk("beq_pcSrc", pcSrcOut, 1'b1);
    chk("beq_target", branchTargetOut, 16'd0);

    // uninterrupted multiply 300*300
    setMul(16'd300, 16'd300);
    tick();
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      chk("mul_bubble_ctrl", ctrlOut, 5'd0);
      scrambleIgnored();
      tick();
    end
    chk("mul_busy_cycles", n, 16);
    chk("mul_result", aluResultOut, 16'h5F90);
    chk("mul_ctrl", ctrlOut, 5'b01000);
    chk("mul_writeReg", writeRegOut, 3'd5);

    // multiply with hit=0 for three cycles mid-run
    setMul(16'd1234, 16'd56);
    tick();
    edges = 1;
    while (busy === 1'b1 && edges < 60) begin
      scrambleIgnored();
      hit = (edges >= 6 && edges <= 8) ? 1'b0 : 1'b1;
      tick();
      edges++;
    end
    chk("stall_latency", edges, 20);
    chk("stall_result", aluResultOut, 16'd3568);

    // flush during MUL cycle 5
    setMul(16'd300, 16'd300);
    tick();
    for (int i = 0; i < 4; i++) tick();
    flush = 1'b1;
    tick();
    chk("flush_busy", busy, 1'b0);
    chk("flush_ctrl", ctrlOut, 5'd0);
    chk("flush_alu", aluResultOut, 16'd0);
    setIdle(); readData1 = 16'd5; readData2 = 16'd7; ctrl = 5'b01000;
    tick();
    chk("after_flush_add", aluResultOut, 16'd12);

    // flush coincident with a mul start
    setMul(16'd3, 16'd4); flush = 1'b1;
    tick();
    chk("flush_start_busy", busy, 1'b0);
    chk("flush_start_ctrl", ctrlOut, 5'd0);
    setIdle();
    tick();
    chk("flush_start_idle", busy, 1'b0);

    // asynchronous reset mid-multiply and mid-cycle
    setIdle(); readData1 = 16'd77; readData2 = 16'd1; rd = 3'd7; regDst = 1'b1; ctrl = 5'b10110;
    tick();
    setMul(16'd300, 16'd300);
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    resetModel();
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu", aluResultOut, 16'd0);
    chk("rst_writeReg", writeRegOut, 3'd0);
    chk("rst_writeData", writeDataOut, 16'd0);
    chk("rst_ctrl", ctrlOut, 5'd0);
    tick();
    #2 rst_n = 1'b1;
    setIdle(); readData1 = 16'hFFFF; readData2 = 16'd1;
    tick();
    chk("wrap_result", aluResultOut, 16'd0);
    chk("wrap_zero", zeroOut, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hit = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 15) == 0);
      ALUOp = 2'($urandom_range(0, 3));
      opCode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin ALUOp = 2'b10; opCode = 3'b101; end
      readData1 = 16'($urandom);
      readData2 = ($urandom_range(0, 5) == 0) ? readData1 : 16'($urandom);
      signExtend = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      ALUSrc = 1'($urandom); regDst = 1'($urandom);
      rt = 3'($urandom); rd = 3'($urandom);
      ctrl = 5'($urandom); nextinst = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
